// File: rtl/vending_pkg.sv
// vending_pkg
//   Shared definitions for the vending-machine datapath: coin values in
//   0.5-yuan units, the dispenser FSM state encoding, coin selector codes,
//   and the credit ceiling shared with the coin collector.
//   No ports (package).
package vending_pkg;

  localparam logic [7:0] COIN_TEN_UNITS  = 8'd20;
  localparam logic [7:0] COIN_ONE_UNITS  = 8'd2;
  localparam logic [7:0] COIN_HALF_UNITS = 8'd1;

  localparam int DEFAULT_MAX_AMOUNT = 30;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_TEN  = 2'd1,
    COIN_ONE  = 2'd2,
    COIN_HALF = 2'd3
  } coin_t;

  function automatic logic [7:0] coin_units(input coin_t c);
    case (c)
      COIN_TEN:  return COIN_TEN_UNITS;
      COIN_ONE:  return COIN_ONE_UNITS;
      COIN_HALF: return COIN_HALF_UNITS;
      default:   return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// coin_pulse_timer
//   Down-counter shared by the coin-pulse and inter-coin gap phases. Loading
//   N-1 makes tc rise on the N-th cycle after the load edge.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   load      in   load load_val on the next rising edge
//   load_val  in   W  cycle count minus one
//   tc        out  terminal count (counter at zero)
module coin_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Latches the customer's credit on a refund request and pays it out one
//   hopper pulse at a time, largest coin first.
//   Optional build macro: CHANGE_HALF_COIN_EN enables the 0.5-yuan coin so
//   odd credit is returned completely; without it coin_half is tied 0 and a
//   final single unit is reported through residue.
//
//   state  | meaning
//   IDLE   | waiting for a refund_req rising edge
//   SELECT | wait for hopper_ready, then pick the largest coin that fits
//   PULSE  | coin output held high for PULSE_CYCLES
//   GAP    | all coin outputs low for GAP_CYCLES
//   DONE   | one-cycle done pulse, residue reported
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-low reset
//   refund_req    in   refund request (rising edge triggers)
//   amount_value  in   8  credit from collector, 0.5-yuan units
//   hopper_ready  in   hopper can accept a pulse
//   coin_ten      out  eject one 10-yuan coin
//   coin_one      out  eject one 1-yuan coin
//   coin_half     out  eject one 0.5-yuan coin (0 unless half coin enabled)
//   clear_credit  out  one-cycle pulse to zero the collector credit
//   busy          out  high from acceptance until back in IDLE
//   done          out  one-cycle pulse at end of dispensing
//   residue       out  undispensable credit remained; held until next accept
//   remaining     out  8  credit still to dispense
module change_dispenser
  import vending_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int MAX_AMOUNT   = DEFAULT_MAX_AMOUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       refund_req,
  input  logic [7:0] amount_value,
  input  logic       hopper_ready,
  output logic       coin_ten,
  output logic       coin_one,
  output logic       coin_half,
  output logic       clear_credit,
  output logic       busy,
  output logic       done,
  output logic       residue,
  output logic [7:0] remaining
);

  localparam logic [7:0] MAX_U      = 8'(MAX_AMOUNT);
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  coin_t      coin_q, coin_nxt;
  logic       req_q;
  logic       req_rise;
  logic       accept;
  logic [7:0] remaining_q;
  logic [7:0] clamped;
  logic       clear_q;
  logic       busy_q;
  logic       residue_q;
  logic       timer_load;
  logic [7:0] timer_val;
  logic       timer_tc;

  // req_q tracks refund_req in every state, so a request held high across
  // the return to IDLE never looks like a fresh edge.
  assign req_rise = refund_req & ~req_q;
  assign accept   = (state == ST_IDLE) && req_rise && (amount_value != 8'd0);
  assign clamped  = (amount_value > MAX_U) ? MAX_U : amount_value;

  coin_pulse_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      coin_q <= COIN_NONE;
    end else begin
      state  <= state_nxt;
      coin_q <= coin_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    coin_nxt   = coin_q;
    timer_load = 1'b0;
    timer_val  = 8'd0;
    coin_ten   = 1'b0;
    coin_one   = 1'b0;
    coin_half  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_rise) begin
          state_nxt = (amount_value != 8'd0) ? ST_SELECT : ST_DONE;
        end
      end
      ST_SELECT: begin
        if (hopper_ready) begin
          if (remaining_q >= COIN_TEN_UNITS) begin
            coin_nxt   = COIN_TEN;
            state_nxt  = ST_PULSE;
            timer_load = 1'b1;
            timer_val  = PULSE_LOAD;
          end else if (remaining_q >= COIN_ONE_UNITS) begin
            coin_nxt   = COIN_ONE;
            state_nxt  = ST_PULSE;
            timer_load = 1'b1;
            timer_val  = PULSE_LOAD;
`ifdef CHANGE_HALF_COIN_EN
          end else if (remaining_q == COIN_HALF_UNITS) begin
            coin_nxt   = COIN_HALF;
            state_nxt  = ST_PULSE;
            timer_load = 1'b1;
            timer_val  = PULSE_LOAD;
`endif
          end else begin
            coin_nxt  = COIN_NONE;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_PULSE: begin
        coin_ten = (coin_q == COIN_TEN);
        coin_one = (coin_q == COIN_ONE);
`ifdef CHANGE_HALF_COIN_EN
        coin_half = (coin_q == COIN_HALF);
`endif
        if (timer_tc) begin
          state_nxt  = ST_GAP;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (timer_tc) begin
          state_nxt = ST_SELECT;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        coin_nxt  = COIN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= 1'b0;
      remaining_q <= 8'd0;
      clear_q     <= 1'b0;
      busy_q      <= 1'b0;
      residue_q   <= 1'b0;
    end else begin
      req_q   <= refund_req;
      clear_q <= accept;
      if (accept) begin
        remaining_q <= clamped;
        busy_q      <= 1'b1;
        residue_q   <= 1'b0;
      end else begin
        if ((state == ST_PULSE) && timer_tc) begin
          remaining_q <= remaining_q - coin_units(coin_q);
        end
        // Residue is judged on entry to DONE so it is valid alongside done.
        if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
          residue_q <= (remaining_q != 8'd0);
        end
        if (state == ST_DONE) begin
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign clear_credit = clear_q;
  assign busy         = busy_q;
  assign residue      = residue_q;
  assign remaining    = remaining_q;

endmodule
